// File: rtl/vexriscv_dbus_mem_bridge.sv
// Purpose: bridges the VexRiscv dBus to a fixed-latency SRAM port. It splits line refills into DATA_W beats
//          and range-checks every access.
// Latency: beat 0 is issued combinationally in the accept cycle. Every response beat follows its issue by exactly MEM_LATENCY cycles.
// Backpressure: cmd_ready is low while the remaining beats of a multi-beat read are issued. Responses never stall.
//
// Ports:
//   clk, reset                     clock and asynchronous active-high reset
//   dBus_cmd_*                     core command channel (valid/ready, wr, address, data, mask, size)
//   dBus_rsp_*                     response beats (valid, last, data, error), one per read beat
//   mem_req/we/addr/be/wdata       SRAM request, DATA_W aligned
//   mem_rdata                      SRAM read data, valid MEM_LATENCY cycles after a read request
module vexriscv_dbus_mem_bridge #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                MEM_LATENCY = 1,
    parameter int                MAX_SIZE    = 6,
    parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] ADDR_SIZE   = 32'h0001_0000,
    parameter bit                WRITE_RSP   = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dBus_cmd_valid,
    output logic                dBus_cmd_ready,
    input  logic                dBus_cmd_payload_wr,
    input  logic                dBus_cmd_payload_uncached,
    input  logic [ADDR_W-1:0]   dBus_cmd_payload_address,
    input  logic [DATA_W-1:0]   dBus_cmd_payload_data,
    input  logic [DATA_W/8-1:0] dBus_cmd_payload_mask,
    input  logic [2:0]          dBus_cmd_payload_size,
    input  logic                dBus_cmd_payload_last,
    output logic                dBus_rsp_valid,
    output logic                dBus_rsp_payload_last,
    output logic [DATA_W-1:0]   dBus_rsp_payload_data,
    output logic                dBus_rsp_payload_error,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int                BYTES      = DATA_W / 8;
    localparam int                LOG_BYTES  = $clog2(BYTES);
    localparam logic [2:0]        LOG_BYTES3 = 3'(LOG_BYTES);
    localparam logic [3:0]        MAX_SIZE4  = 4'(MAX_SIZE);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] BEAT_STEP  = ADDR_W'(BYTES);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state;
    logic [ADDR_W-1:0] burst_addr;
    logic [7:0]        burst_left;   // beats still to issue, including the current one
    logic              burst_err;

    logic              cmd_accept;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_off;
    logic              cmd_legal;
    logic [7:0]        cmd_beats;

    logic              issue_vld;
    logic              issue_wr;
    logic              issue_err;
    logic              issue_last;
    logic [ADDR_W-1:0] issue_addr;
    logic [BYTES-1:0]  issue_be;
    logic [DATA_W-1:0] issue_wdata;
    logic              load_vld;

    logic [MEM_LATENCY-1:0] pipe_vld;
    logic [MEM_LATENCY-1:0] pipe_err;
    logic [MEM_LATENCY-1:0] pipe_last;
    logic [MEM_LATENCY-1:0] pipe_wr;

    // The core sends these fields, but they carry nothing this bridge needs.
    logic unused_inputs;
    assign unused_inputs = dBus_cmd_payload_uncached ^ dBus_cmd_payload_last;

    assign dBus_cmd_ready = (state == IDLE);
    assign cmd_accept     = dBus_cmd_valid && dBus_cmd_ready;
    assign cmd_addr       = dBus_cmd_payload_address & ~ALIGN_MASK;

    // The window check uses one extra bit so that addresses below ADDR_BASE show up as a borrow.
    assign cmd_off   = {1'b0, cmd_addr} - {1'b0, ADDR_BASE};
    assign cmd_legal = !cmd_off[ADDR_W] && (cmd_off[ADDR_W-1:0] < ADDR_SIZE)
                       && ({1'b0, dBus_cmd_payload_size} <= MAX_SIZE4);

    // Only reads are split into beats. A write is always a single beat.
    always_comb begin
        cmd_beats = 8'd1;
        if (!dBus_cmd_payload_wr && (dBus_cmd_payload_size > LOG_BYTES3))
            cmd_beats = 8'd1 << (dBus_cmd_payload_size - LOG_BYTES3);
    end

    // Beat 0 comes straight from the command. Later beats come from the burst registers.
    always_comb begin
        issue_vld   = 1'b0;
        issue_wr    = 1'b0;
        issue_err   = 1'b0;
        issue_last  = 1'b0;
        issue_addr  = cmd_addr;
        issue_be    = '1;
        issue_wdata = '0;
        if (state == BURST) begin
            issue_vld  = 1'b1;
            issue_err  = burst_err;
            issue_last = (burst_left == 8'd1);
            issue_addr = burst_addr;
        end else if (cmd_accept) begin
            issue_vld  = 1'b1;
            issue_wr   = dBus_cmd_payload_wr;
            issue_err  = !cmd_legal;
            issue_last = (cmd_beats == 8'd1);
            if (dBus_cmd_payload_wr) begin
                issue_be    = dBus_cmd_payload_mask;
                issue_wdata = dBus_cmd_payload_data;
            end
        end
    end

    // Illegal beats never reach memory. They still travel down the response pipe.
    assign mem_req   = issue_vld && !issue_err && !reset;
    assign mem_we    = mem_req && issue_wr;
    assign mem_addr  = mem_req ? issue_addr : '0;
    assign mem_be    = mem_req ? issue_be : '0;
    assign mem_wdata = mem_we ? issue_wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            burst_addr <= '0;
            burst_left <= '0;
            burst_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_accept && !dBus_cmd_payload_wr && (cmd_beats > 8'd1)) begin
                        state      <= BURST;
                        burst_addr <= cmd_addr + BEAT_STEP;
                        burst_left <= cmd_beats - 8'd1;
                        burst_err  <= !cmd_legal;
                    end
                end
                BURST: begin
                    burst_addr <= burst_addr + BEAT_STEP;
                    burst_left <= burst_left - 8'd1;
                    if (burst_left == 8'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The response pipe has one stage per cycle of memory latency. This keeps response order
    // and timing identical for legal and illegal beats.
    assign load_vld = issue_vld && (!issue_wr || WRITE_RSP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld  <= '0;
            pipe_err  <= '0;
            pipe_last <= '0;
            pipe_wr   <= '0;
        end else begin
            pipe_vld[0]  <= load_vld;
            pipe_err[0]  <= load_vld && issue_err;
            pipe_last[0] <= load_vld && issue_last;
            pipe_wr[0]   <= load_vld && issue_wr;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_err[i]  <= pipe_err[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_wr[i]   <= pipe_wr[i-1];
            end
        end
    end

    assign dBus_rsp_valid         = pipe_vld[MEM_LATENCY-1];
    assign dBus_rsp_payload_error = pipe_err[MEM_LATENCY-1];
    assign dBus_rsp_payload_last  = pipe_last[MEM_LATENCY-1];
    assign dBus_rsp_payload_data  = (pipe_vld[MEM_LATENCY-1] && !pipe_err[MEM_LATENCY-1]
                                     && !pipe_wr[MEM_LATENCY-1]) ? mem_rdata : '0;
endmodule

// File: tb/tb_vexriscv_dbus_mem_bridge.sv
module tb_vexriscv_dbus_mem_bridge;
    localparam int LAT = 2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic        last;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        v0, v1, c_wr, c_unc, c_last;
    logic [31:0] c_addr, c_data;
    logic [3:0]  c_mask;
    logic [2:0]  c_size;

    logic        rdy0, rv0, rl0, re0, mreq0, mwe0;
    logic [31:0] rd0, maddr0, mwd0, mrd0;
    logic [3:0]  mbe0;
    logic        rdy1, rv1, rl1, re1, mreq1, mwe1;
    logic [31:0] rd1, maddr1, mwd1, mrd1;
    logic [3:0]  mbe1;

    int checks = 0;
    int failures = 0;
    int mreq1_cnt = 0;

    mreq_t exp_mem[$];
    rsp_t  exp_rsp0[$];
    rsp_t  exp_rsp1[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] shadow[logic [31:0]];
    logic [31:0] rd_p0, rd_p1;

    assign mrd0 = rd_p1;
    assign mrd1 = 32'hCAFE_F00D;

    vexriscv_dbus_mem_bridge #(
        .DATA_W(32), .ADDR_W(32), .MEM_LATENCY(LAT), .MAX_SIZE(6),
        .ADDR_BASE(32'h8000_0000), .ADDR_SIZE(32'h0001_0000), .WRITE_RSP(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset),
        .dBus_cmd_valid(v0), .dBus_cmd_ready(rdy0),
        .dBus_cmd_payload_wr(c_wr), .dBus_cmd_payload_uncached(c_unc),
        .dBus_cmd_payload_address(c_addr), .dBus_cmd_payload_data(c_data),
        .dBus_cmd_payload_mask(c_mask), .dBus_cmd_payload_size(c_size),
        .dBus_cmd_payload_last(c_last),
        .dBus_rsp_valid(rv0), .dBus_rsp_payload_last(rl0),
        .dBus_rsp_payload_data(rd0), .dBus_rsp_payload_error(re0),
        .mem_req(mreq0), .mem_we(mwe0), .mem_addr(maddr0), .mem_be(mbe0),
        .mem_wdata(mwd0), .mem_rdata(mrd0)
    );

    vexriscv_dbus_mem_bridge #(
        .DATA_W(32), .ADDR_W(32), .MEM_LATENCY(LAT), .MAX_SIZE(6),
        .ADDR_BASE(32'h8000_0000), .ADDR_SIZE(32'h0001_0000), .WRITE_RSP(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .dBus_cmd_valid(v1), .dBus_cmd_ready(rdy1),
        .dBus_cmd_payload_wr(c_wr), .dBus_cmd_payload_uncached(c_unc),
        .dBus_cmd_payload_address(c_addr), .dBus_cmd_payload_data(c_data),
        .dBus_cmd_payload_mask(c_mask), .dBus_cmd_payload_size(c_size),
        .dBus_cmd_payload_last(c_last),
        .dBus_rsp_valid(rv1), .dBus_rsp_payload_last(rl1),
        .dBus_rsp_payload_data(rd1), .dBus_rsp_payload_error(re1),
        .mem_req(mreq1), .mem_we(mwe1), .mem_addr(maddr1), .mem_be(mbe1),
        .mem_wdata(mwd1), .mem_rdata(mrd1)
    );

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    // SRAM model: byte-enabled writes, reads returned LAT=2 cycles after the request
    always @(posedge clk) begin
        logic [31:0] cur;
        if (mreq0 && mwe0) begin
            cur = mem.exists(maddr0) ? mem[maddr0] : init_val(maddr0);
            for (int b = 0; b < 4; b++)
                if (mbe0[b]) cur[8*b +: 8] = mwd0[8*b +: 8];
            mem[maddr0] = cur;
        end
        if (mreq0 && !mwe0)
            rd_p0 <= mem.exists(maddr0) ? mem[maddr0] : init_val(maddr0);
        else
            rd_p0 <= 32'hBAD0_BAD0;
        rd_p1 <= rd_p0;
    end

    // Scoreboard monitors
    always @(negedge clk) begin
        mreq_t em, gm;
        rsp_t  er, gr;
        if (mreq0) begin
            gm.we = mwe0; gm.addr = maddr0; gm.be = mbe0; gm.wdata = mwd0;
            checks++;
            if (exp_mem.size() == 0) begin
                failures++;
                $display("FAIL mem_unexpected got we=%b addr=%h", mwe0, maddr0);
            end else begin
                em = exp_mem.pop_front();
                if (gm !== em) begin
                    failures++;
                    $display("FAIL mem_req got we=%b addr=%h be=%h wd=%h exp we=%b addr=%h be=%h wd=%h",
                             gm.we, gm.addr, gm.be, gm.wdata, em.we, em.addr, em.be, em.wdata);
                end
            end
        end
        if (rv0) begin
            gr.last = rl0; gr.err = re0; gr.data = rd0;
            checks++;
            if (exp_rsp0.size() == 0) begin
                failures++;
                $display("FAIL rsp0_unexpected got last=%b err=%b data=%h", rl0, re0, rd0);
            end else begin
                er = exp_rsp0.pop_front();
                if (gr !== er) begin
                    failures++;
                    $display("FAIL rsp0 got last=%b err=%b data=%h exp last=%b err=%b data=%h",
                             gr.last, gr.err, gr.data, er.last, er.err, er.data);
                end
            end
        end
        if (rv1) begin
            gr.last = rl1; gr.err = re1; gr.data = rd1;
            checks++;
            if (exp_rsp1.size() == 0) begin
                failures++;
                $display("FAIL rsp1_unexpected got last=%b err=%b data=%h", rl1, re1, rd1);
            end else begin
                er = exp_rsp1.pop_front();
                if (gr !== er) begin
                    failures++;
                    $display("FAIL rsp1 got last=%b err=%b data=%h exp last=%b err=%b data=%h",
                             gr.last, gr.err, gr.data, er.last, er.err, er.data);
                end
            end
        end
        if (mreq1) mreq1_cnt++;
    end

    task automatic push_memrd(input logic [31:0] a);
        mreq_t m;
        m.we = 1'b0; m.addr = a; m.be = 4'hF; m.wdata = 32'h0;
        exp_mem.push_back(m);
    endtask

    task automatic push_rd(input logic [31:0] a, input bit last);
        rsp_t r;
        push_memrd(a);
        r.last = last; r.err = 1'b0; r.data = sh_rd(a);
        exp_rsp0.push_back(r);
    endtask

    task automatic push_err(input bit last);
        rsp_t r;
        r.last = last; r.err = 1'b1; r.data = 32'h0;
        exp_rsp0.push_back(r);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        mreq_t e;
        logic [31:0] cur;
        e.we = 1'b1; e.addr = a; e.be = m; e.wdata = d;
        exp_mem.push_back(e);
        cur = sh_rd(a);
        for (int b = 0; b < 4; b++)
            if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
        shadow[a] = cur;
    endtask

    // Must be entered just after a rising edge. Returns just after the accepting edge.
    task automatic send(input bit to1, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [2:0] s);
        int n;
        c_wr = w; c_addr = a; c_data = d; c_mask = m; c_size = s;
        v0 = !to1; v1 = to1;
        n = 0;
        @(negedge clk);
        while (!(to1 ? rdy1 : rdy0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            failures++;
            $display("FAIL cmd_accept_timeout addr=%h ready never rose", a);
        end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; v0 = 0; v1 = 0; c_wr = 0; c_unc = 0; c_last = 0;
        c_addr = 0; c_data = 0; c_mask = 0; c_size = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy0); end
        checks++;
        if ({rv0, rl0, re0, rd0} !== 35'h0) begin
            failures++; $display("FAIL reset_rsp got v=%b l=%b e=%b d=%h exp all 0", rv0, rl0, re0, rd0);
        end
        checks++;
        if ({mreq0, mwe0, maddr0, mbe0, mwd0} !== 70'h0) begin
            failures++; $display("FAIL reset_mem got req=%b addr=%h exp all 0", mreq0, maddr0);
        end
        checks++;
        if (rdy1 !== 1'b1 || rv1 !== 1'b0) begin
            failures++; $display("FAIL reset_dut1 got rdy=%b rv=%b exp 1/0", rdy1, rv1);
        end
        // A command presented while reset is held must not reach memory.
        c_addr = 32'h8000_0000; c_size = 3'd2; v0 = 1'b1;
        @(negedge clk);
        checks++;
        if (mreq0 !== 1'b0) begin failures++; $display("FAIL reset_cmd_blocked got mem_req=%b exp=0", mreq0); end
        v0 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_write();
        push_wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        send(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2);
        idle(6);
        checks++;
        if (exp_mem.size() != 0 || exp_rsp0.size() != 0) begin
            failures++; $display("FAIL write_drain got mem_q=%0d rsp_q=%0d exp 0/0", exp_mem.size(), exp_rsp0.size());
        end
    endtask

    task automatic test_read_single();
        push_rd(32'h8000_0010, 1'b1);
        send(0, 0, 32'h8000_0010, 32'h0, 4'h0, 3'd2);
        @(negedge clk);
        checks++;
        if (rv0 !== 1'b0) begin failures++; $display("FAIL read_lat1 got rsp_valid=%b exp=0", rv0); end
        @(negedge clk);
        checks++;
        if (rv0 !== 1'b1 || rd0 !== 32'hDEAD_BEEF || rl0 !== 1'b1 || re0 !== 1'b0) begin
            failures++;
            $display("FAIL read_lat2 got v=%b d=%h l=%b e=%b exp 1/deadbeef/1/0", rv0, rd0, rl0, re0);
        end
        @(posedge clk); #1;
        // Partial write followed immediately by a read of the same word.
        push_wr(32'h8000_0014, 32'h1111_2222, 4'h3);
        send(0, 1, 32'h8000_0014, 32'h1111_2222, 4'h3, 3'd1);
        push_rd(32'h8000_0014, 1'b1);
        send(0, 0, 32'h8000_0014, 32'h0, 4'h0, 3'd2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rv0 !== 1'b1 || rd0 !== 32'hDA5A_2222) begin
            failures++; $display("FAIL partial_write got v=%b d=%h exp 1/da5a2222", rv0, rd0);
        end
        idle(4);
        checks++;
        if (exp_mem.size() != 0 || exp_rsp0.size() != 0) begin
            failures++; $display("FAIL read_drain got mem_q=%0d rsp_q=%0d exp 0/0", exp_mem.size(), exp_rsp0.size());
        end
    endtask

    task automatic test_burst();
        int low;
        for (int k = 0; k < 8; k++) push_rd(32'h8000_0040 + 32'(4*k), k == 7);
        send(0, 0, 32'h8000_0040, 32'h0, 4'h0, 3'd5);
        low = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (rdy0 === 1'b0) low++;
        end
        checks++;
        if (low != 7) begin failures++; $display("FAIL burst_ready_low got=%0d cycles exp=7", low); end
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin failures++; $display("FAIL burst_ready_back got=%b exp=1", rdy0); end
        @(posedge clk); #1;
        idle(6);
        checks++;
        if (exp_mem.size() != 0 || exp_rsp0.size() != 0) begin
            failures++; $display("FAIL burst_drain got mem_q=%0d rsp_q=%0d exp 0/0", exp_mem.size(), exp_rsp0.size());
        end
    endtask

    task automatic test_back_to_back();
        push_err(1'b1);
        push_rd(32'h8000_0010, 1'b1);
        send(0, 0, 32'h7FFF_FFF0, 32'h0, 4'h0, 3'd2);
        send(0, 0, 32'h8000_0010, 32'h0, 4'h0, 3'd2);
        // A burst followed by a read while burst responses are still in flight
        for (int k = 0; k < 4; k++) push_rd(32'h8000_0200 + 32'(4*k), k == 3);
        push_rd(32'h8000_0014, 1'b1);
        send(0, 0, 32'h8000_0200, 32'h0, 4'h0, 3'd4);
        send(0, 0, 32'h8000_0014, 32'h0, 4'h0, 3'd2);
        idle(6);
        checks++;
        if (exp_mem.size() != 0 || exp_rsp0.size() != 0) begin
            failures++; $display("FAIL b2b_drain got mem_q=%0d rsp_q=%0d exp 0/0", exp_mem.size(), exp_rsp0.size());
        end
    endtask

    task automatic test_boundary();
        push_rd(32'h8000_FFFC, 1'b1);                  // last legal word
        send(0, 0, 32'h8000_FFFC, 32'h0, 4'h0, 3'd2);
        push_err(1'b1);                                // first word past the window
        send(0, 0, 32'h8001_0000, 32'h0, 4'h0, 3'd2);
        push_rd(32'h8000_0010, 1'b1);                  // byte read, misaligned address
        send(0, 0, 32'h8000_0013, 32'h0, 4'h0, 3'd0);
        push_rd(32'h8000_0104, 1'b0);                  // 2-beat read from a non-line-aligned word
        push_rd(32'h8000_0108, 1'b1);
        send(0, 0, 32'h8000_0106, 32'h0, 4'h0, 3'd3);
        for (int k = 0; k < 32; k++) push_err(k == 31); // size above MAX_SIZE: every beat errors
        send(0, 0, 32'h8000_0000, 32'h0, 4'h0, 3'd7);
        idle(40);
        checks++;
        if (exp_mem.size() != 0 || exp_rsp0.size() != 0) begin
            failures++; $display("FAIL boundary_drain got mem_q=%0d rsp_q=%0d exp 0/0", exp_mem.size(), exp_rsp0.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        push_rd(32'h8000_0080, 1'b0);      // beat 0 responds before the reset
        push_memrd(32'h8000_0084);
        push_memrd(32'h8000_0088);
        send(0, 0, 32'h8000_0080, 32'h0, 4'h0, 3'd5);
        idle(2);                            // now in the 4th cycle of the burst
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (rv0 !== 1'b0 || rdy0 !== 1'b1 || mreq0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got rv=%b rdy=%b req=%b exp 0/1/0", rv0, rdy0, mreq0);
        end
        @(posedge clk); #1;
        idle(1);
        reset = 1'b0;
        idle(12);
        checks++;
        if (exp_mem.size() != 0 || exp_rsp0.size() != 0) begin
            failures++; $display("FAIL reset_drain got mem_q=%0d rsp_q=%0d exp 0/0", exp_mem.size(), exp_rsp0.size());
        end
    endtask

    task automatic test_write_rsp();
        int c0;
        rsp_t r;
        c0 = mreq1_cnt;
        r.last = 1'b1; r.err = 1'b1; r.data = 32'h0;
        exp_rsp1.push_back(r);
        send(1, 1, 32'h8001_0000, 32'h1234_5678, 4'hF, 3'd2);
        @(negedge clk);
        checks++;
        if (rv1 !== 1'b0) begin failures++; $display("FAIL wrsp_lat1 got rsp_valid=%b exp=0", rv1); end
        @(negedge clk);
        checks++;
        if (rv1 !== 1'b1 || re1 !== 1'b1 || rl1 !== 1'b1) begin
            failures++; $display("FAIL wrsp_err got v=%b e=%b l=%b exp 1/1/1", rv1, re1, rl1);
        end
        checks++;
        if (mreq1_cnt != c0) begin failures++; $display("FAIL wrsp_no_mem got=%0d reqs exp=0", mreq1_cnt - c0); end
        @(posedge clk); #1;
        r.last = 1'b1; r.err = 1'b0; r.data = 32'h0;
        exp_rsp1.push_back(r);
        send(1, 1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 3'd2);
        idle(5);
        checks++;
        if (mreq1_cnt != c0 + 1) begin failures++; $display("FAIL wrsp_legal_mem got=%0d reqs exp=1", mreq1_cnt - c0); end
        checks++;
        if (exp_rsp1.size() != 0) begin failures++; $display("FAIL wrsp_drain got rsp_q=%0d exp=0", exp_rsp1.size()); end
    endtask

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_single();
        test_burst();
        test_back_to_back();
        test_boundary();
        test_reset_mid_burst();
        test_write_rsp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
